mmm_final_reduce: RTL and testbench
===================================

MMM_FINAL_REDUCE -- requirements
Module: mmm_final_reduce

Interface
REQ-001 SHALL have parameter: dw, default 6, operand/modulus width in bits.
REQ-002 SHALL have parameter: w, default 3, PE word width in bits; dw SHALL be a multiple of w.
REQ-003 SHALL derive local constant E = dw/w + 1, the number of result words (E*w bits, covering S < 2M).
REQ-004 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: s_valid  input  1  result word from last PE stage is present.
REQ-007 SHALL have port: s_word  input  w  result word S_k, least significant word first.
REQ-008 SHALL have port: s_ready  output  1  block accepts a word this cycle.
REQ-009 SHALL have port: m  input  dw  modulus M.
REQ-010 SHALL have port: r_valid  output  1  reduced result available.
REQ-011 SHALL have port: r_data  output  dw  reduced result R = S mod-corrected.
REQ-012 SHALL have port: r_ready  input  1  consumer takes result.
REQ-013 SHALL have port: ovf  output  1  selected result still >= M (input S was >= 2M).

Function
REQ-014 SHALL implement two states: COLLECT and OUT; s_ready = 1 exactly when state is COLLECT and rst is low.
REQ-015 SHALL accept a word only on a cycle with s_valid && s_ready; s_word SHALL be ignored on all other cycles.
REQ-016 SHALL keep word counter cnt in 0..E-1; accepted word k SHALL be stored at S bits [k*w +: w].
REQ-017 SHALL capture m into an internal M register on acceptance of word 0 and use m directly for word 0's subtraction; later changes to m SHALL NOT affect the result in progress.
REQ-018 SHALL compute D word-serially on each accept: {borrow, D_k} = S_k - M_k - borrow, M zero-extended to E*w bits, borrow cleared to 0 at word 0.
REQ-019 SHALL, on acceptance of word E-1, go to OUT and on that same edge register r_data = D[dw-1:0] if final borrow is 0, else S[dw-1:0]; r_valid = 1 from the next cycle (latency 1 cycle after last word).
REQ-020 SHALL register ovf with r_data: 1 if the selected E*w-bit value has any bit set at or above bit dw, or its low dw bits are >= M; otherwise 0.
REQ-021 SHALL hold r_valid, r_data and ovf stable in OUT until a cycle with r_valid && r_ready.
REQ-022 SHALL, on r_valid && r_ready, return to COLLECT with cnt = 0 and borrow = 0; r_valid SHALL be 0 in the following cycle.
REQ-023 SHALL NOT accept a new word in the same cycle as the result handshake; s_ready = 0 throughout OUT.
REQ-024 SHALL treat cnt wrap-around only via REQ-022; cnt SHALL never exceed E-1.
REQ-025 SHALL NOT retain partial S, D, borrow or cnt across a reset.

Reset
REQ-026 SHALL, while rst is high, immediately force: state COLLECT, cnt 0, borrow 0, S/D/M registers 0, r_valid 0, r_data 0, ovf 0, s_ready 0.
REQ-027 SHALL assert s_ready = 1 in the first cycle after rst deasserts; a reset asserted mid-collection or in OUT SHALL abandon that result with no r_valid pulse.

Verification (dw=6, w=3, E=3, M=45)
REQ-028 SHALL cover: S=50, words 2,6,0 -> r_valid one cycle after third accept, r_data=5, ovf=0.
REQ-029 SHALL cover: S=30, words 6,3,0 -> r_data=30, ovf=0; S=45, words 5,5,0 -> r_data=0, ovf=0.
REQ-030 SHALL cover: S=100, words 4,4,1 -> r_data=55, ovf=1.
REQ-031 SHALL cover: result pending with r_ready low 5 cycles, s_valid held high with changing s_word -> r_data stable, s_ready=0, no words consumed; then r_ready=1 -> r_valid=0 next cycle, s_ready=1.
REQ-032 SHALL cover: rst pulse after two accepted words -> no r_valid; next three words 2,6,0 -> r_data=5.
REQ-033 SHALL cover: s_valid gaps between words and m changed to 7 after word 0 -> result still computed with M=45.

Source files
------------

// File: rtl/mmm_final_reduce_if.sv
// mmm_final_reduce_if: word stream in, reduced result out, plus modulus input
interface mmm_final_reduce_if #(parameter int dw = 6, parameter int w = 3);
  logic          s_valid;
  logic [w-1:0]  s_word;
  logic          s_ready;
  logic [dw-1:0] m;
  logic          r_valid;
  logic [dw-1:0] r_data;
  logic          r_ready;
  logic          ovf;
  modport master (output s_valid, s_word, m, r_ready, input s_ready, r_valid, r_data, ovf);
  modport slave  (input s_valid, s_word, m, r_ready, output s_ready, r_valid, r_data, ovf);
endinterface

// File: rtl/mmm_final_reduce.sv
// mmm_final_reduce: collects S word-serially while computing S-M, then picks S or S-M
module mmm_final_reduce #(
    parameter int dw = 6,
    parameter int w  = 3
) (
    input logic clk,
    input logic rst,
    mmm_final_reduce_if.slave bus
);
    localparam int E  = dw / w + 1;
    localparam int ew = E * w;
    localparam int cw = $clog2(E);
    localparam int w1 = w + 1;
    typedef enum logic {COLLECT, OUT} state_t;
    state_t state, state_n;
    logic [cw-1:0] cnt;
    logic [ew-1:0] s_q, d_q, s_n, d_n, sel, m_ext;
    logic [dw-1:0] m_q, m_cur, r_data_q;
    logic borrow, acc, last, hs, ovf_q, ovf_n;
    logic [w:0] diff;
    assign bus.s_ready = state == COLLECT && !rst;
    assign bus.r_valid = state == OUT;
    assign bus.r_data  = r_data_q;
    assign bus.ovf     = ovf_q;
    always_comb begin
        acc   = bus.s_valid && bus.s_ready;
        last  = cnt == cw'(E - 1);
        hs    = bus.r_valid && bus.r_ready;
        // word 0 subtracts the live modulus; later words use the captured copy
        m_cur = cnt == '0 ? bus.m : m_q;
        m_ext = ew'(m_cur);
        diff  = {1'b0, bus.s_word} - {1'b0, m_ext[cnt*w +: w]} - w1'(cnt != '0 && borrow);
        s_n   = s_q;
        s_n[cnt*w +: w] = bus.s_word;
        d_n   = d_q;
        d_n[cnt*w +: w] = diff[w-1:0];
        sel   = diff[w] ? s_n : d_n;
        ovf_n = |sel[ew-1:dw] || sel[dw-1:0] >= m_cur;
        state_n = state == COLLECT ? (acc && last ? OUT : COLLECT) : (hs ? COLLECT : OUT);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= COLLECT;
        else     state <= state_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            borrow   <= 1'b0;
            s_q      <= '0;
            d_q      <= '0;
            m_q      <= '0;
            r_data_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (acc) begin
                s_q    <= s_n;
                d_q    <= d_n;
                borrow <= diff[w];
                if (!last) cnt <= cnt + 1'b1;
                if (cnt == '0) m_q <= bus.m;
                if (last) begin
                    r_data_q <= sel[dw-1:0];
                    ovf_q    <= ovf_n;
                end
            end
            if (hs) begin
                cnt    <= '0;
                borrow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mmm_final_reduce.sv
// tb_mmm_final_reduce: directed scoreboard bench for the final Montgomery reduction stage
module tb_mmm_final_reduce;
  typedef struct packed {logic [5:0] d; logic o;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  mmm_final_reduce_if #(.dw(6), .w(3)) bus ();
  mmm_final_reduce #(.dw(6), .w(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input int s, input int m);
    int r;
    exp_t e;
    r = s >= m ? s - m : s;
    e.d = 6'(r);
    e.o = r >= m;
    return e;
  endfunction
  task automatic send(input logic [2:0] wd);
    bus.s_valid = 1'b1;
    bus.s_word  = wd;
    chk("s_ready_before_accept", bus.s_ready, 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic txn(input int s, input int gap);
    sb.push_back(model(s, 45));
    for (int k = 0; k < 3; k++) begin
      send(3'((s >> (3 * k)) & 7));
      if (k < 2) idle(gap);
    end
  endtask
  task automatic get_result(input string tag);
    int waited;
    exp_t e;
    waited = 0;
    while (!bus.r_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_latency"}, waited, 0);
    chk({tag, "_r_valid"}, bus.r_valid, 1);
    chk({tag, "_s_ready_out"}, bus.s_ready, 0);
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_r_data"}, bus.r_data, e.d);
      chk({tag, "_ovf"}, bus.ovf, e.o);
    end
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
    bus.s_valid = 1'b0;
    chk({tag, "_r_valid_after_hs"}, bus.r_valid, 0);
    chk({tag, "_s_ready_after_hs"}, bus.s_ready, 1);
  endtask
  initial begin
    bus.s_valid = 1'b0;
    bus.s_word  = '0;
    bus.m       = 6'd45;
    bus.r_ready = 1'b0;
    idle(2);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_r_valid", bus.r_valid, 0);
    chk("rst_r_data", bus.r_data, 0);
    chk("rst_ovf", bus.ovf, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", bus.s_ready, 1);
    txn(50, 0);
    get_result("s50");
    txn(30, 0);
    get_result("s30");
    txn(45, 0);
    get_result("s45");
    txn(100, 0);
    get_result("s100");
    txn(90, 1);
    get_result("s90");
    txn(44, 2);
    get_result("s44");
    // result held while the producer keeps offering words
    txn(50, 0);
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = 1'b1;
      bus.s_word  = 3'(i + 1);
      @(negedge clk);
      chk("hold_r_valid", bus.r_valid, 1);
      chk("hold_s_ready", bus.s_ready, 0);
      chk("hold_r_data", bus.r_data, 5);
    end
    bus.s_word = 3'd7;
    get_result("hold");
    txn(30, 0);
    get_result("after_hold");
    // reset abandons a partial collection
    send(3'd1);
    send(3'd1);
    rst = 1'b1;
    #1;
    chk("midrst_s_ready", bus.s_ready, 0);
    chk("midrst_r_valid", bus.r_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("midrst_no_r_valid", bus.r_valid, 0);
    txn(50, 0);
    get_result("after_rst");
    // modulus change after word 0 must not affect the result
    sb.push_back(model(50, 45));
    send(3'd2);
    bus.m = 6'd7;
    idle(2);
    send(3'd6);
    idle(3);
    send(3'd0);
    get_result("m_change");
    bus.m = 6'd45;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
